lfsr_byte_packer: RTL and testbench
===================================

// Module: lfsr_byte_packer
// PURPOSE
//  Downstream consumer and controller of the 4-bit serial LFSR. Seeds it via LOAD/SEED, samples its Q bit every clock, and packs the bits MSB-first into bytes.
//  Bytes are buffered in a small FIFO and presented to the host-transfer side on a valid/ready byte interface.
//  Produces a fixed-length pseudo-random byte stream for the transfer demo.
// PARAMETERS
//  FIFO_DEPTH  16  byte entries in output FIFO; power of 2, >=2
//  LEN_W       16  width of byte-count request
// PORTS
//  CLK         in   1      single clock; all logic rising-edge
//  RST         in   1      synchronous, active-high reset
//  START       in   1      1-cycle pulse: begin run (ignored unless IDLE)
//  SEED        in   4      seed captured at START
//  BYTE_LEN    in   LEN_W  bytes to generate, captured at START; 0 = no-op
//  LFSR_LOAD   out  1      to LFSR LOAD
//  LFSR_SEED   out  4      to LFSR SEED
//  LFSR_Q      in   1      from LFSR Q
//  DOUT        out  8      head-of-FIFO byte
//  DOUT_VALID  out  1      FIFO not empty
//  DOUT_READY  in   1      consumer accepts DOUT when VALID&READY
//  BUSY        out  1      FSM not IDLE
//  DONE        out  1      1-cycle pulse when last byte written or dropped
//  SEED_ERR    out  1      1-cycle pulse: START with SEED==0 rejected
//  OVERFLOW    out  1      sticky: byte dropped on full FIFO; cleared by RST/next accepted START
// BEHAVIOUR
//  Reset: all outputs 0; LFSR_SEED=0; FSM=IDLE; FIFO empty; bit/byte counters 0.
//  FSM states and transitions:
//   IDLE->LOAD on START & SEED!=0 & BYTE_LEN!=0.
//   START & SEED==0: stay IDLE, pulse SEED_ERR next cycle. This check takes priority over BYTE_LEN==0.
//   START & BYTE_LEN==0 (SEED!=0): stay IDLE, pulse DONE next cycle.
//   LOAD: LFSR_LOAD=1, LFSR_SEED=captured seed, exactly 1 cycle ->RUN.
//   RUN: sample LFSR_Q every cycle (LFSR free-runs, no stall) into 8-bit shift reg, MSB first.
//   On 8th bit the byte is pushed to the FIFO in that same cycle; bit counter wraps 7->0 with no gap between bytes.
//   RUN->IDLE after byte BYTE_LEN is pushed or dropped; DONE pulses the following cycle.
//  Latency: first Q sampled in the cycle after LOAD. The first byte is visible at DOUT_VALID 9 cycles after the LOAD cycle.
//  FIFO full at byte completion: byte dropped, OVERFLOW set, byte still counted toward BYTE_LEN.
//  Simultaneous push and pop when full: the pop frees the slot and the push succeeds (no drop).
//  Pop when empty: no effect. Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
//  START while BUSY: ignored, no side effects.
//  FIFO contents survive end of run; the consumer drains after DONE.
//  RST mid-run: immediate IDLE, FIFO flushed, partial byte discarded, LFSR_LOAD=0.
// CONFIGURATION
//  LFSR_PACK_DROP_CNT_EN defined:
//   Adds output DROP_CNT[7:0] = bytes dropped since last accepted START; saturates at 8'hFF; reset 0.
//  LFSR_PACK_DROP_CNT_EN undefined: port and counter absent; OVERFLOW behaviour unchanged.
// STRUCTURE
//  Package lfsr_pack_pkg:
//   FSM state enum {IDLE, LOAD, RUN};
//   constants BYTE_W=8, SEED_W=4.
//  Sub-module lfsr_pack_fifo: synchronous single-clock FIFO (push/pop/full/empty, first-word-fall-through DOUT).
//   The packer instantiates it once.
//  Bench instantiates the packer together with the real LFSR.
// TESTING
//  T1: SEED=4'h1, BYTE_LEN=1, READY=1 -> first byte DOUT=8'h35; DONE pulses once; BUSY returns 0.
//  T2: SEED=4'h1, BYTE_LEN=15, READY=1 -> 15 bytes; sequence repeats every 15 bits, matches LFSR model; OVERFLOW=0.
//  T3: BYTE_LEN=20, READY=0 -> 16 bytes held, 4 dropped, OVERFLOW=1 (DROP_CNT=4 with macro).
//   Then drain with READY=1 -> exactly 16 bytes, in order.
//  T4: START with SEED=0 -> SEED_ERR pulse, BUSY stays 0, LFSR_LOAD never asserted.
//   START with BYTE_LEN=0 -> DONE pulse only.
//  T5: RST asserted 5 cycles into RUN -> next cycle BUSY=0, DOUT_VALID=0.
//   New START then produces the T1 byte 8'h35 again.
//  T6: FIFO full, READY=1 exactly on the byte-completion cycle -> no drop, OVERFLOW stays 0.
//   Second START while BUSY -> ignored.

Source files
------------

// File: rtl/lfsr_pack_pkg.sv
// Shared types and constants for the LFSR byte packer.
// FSM state encoding, byte/seed widths and the bit-packing helper.
package lfsr_pack_pkg;

  localparam int BYTE_W    = 8;
  localparam int SEED_W    = 4;
  localparam int BIT_CNT_W = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Completes a byte: seven earlier bits in the high positions, newest bit as LSB.
  function automatic logic [BYTE_W-1:0] pack_bit(input logic [BYTE_W-2:0] partial,
                                                 input logic              b);
    return {partial, b};
  endfunction

endpackage

// File: rtl/lfsr_byte_packer_if.sv
// Valid/ready byte stream between the packer (master) and the host-transfer side (slave).
interface lfsr_byte_packer_if;

  logic [lfsr_pack_pkg::BYTE_W-1:0] data;
  logic                             valid;
  logic                             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/lfsr4.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1): Q is the feedback bit, which is also shifted in.
// LOAD overrides the state with SEED; otherwise the register free-runs every clock.
module lfsr4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] seed_i,
  output logic       q_o
);

  logic [3:0] state_q;

  assign q_o = state_q[3] ^ state_q[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 4'h1;
    end else if (load_i) begin
      state_q <= seed_i;
    end else begin
      state_q <= {state_q[2:0], q_o};
    end
  end

endmodule

// File: rtl/lfsr_pack_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module lfsr_pack_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         accept_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop_ok;
  logic          full;

  assign empty_o  = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_ok   = pop_i && !empty_o;
  assign accept_o = push_i && (!full || pop_ok);
  assign data_o   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (accept_o) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept_o) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({accept_o, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lfsr_byte_packer.sv
// Seeds a 4-bit serial LFSR, packs its Q stream MSB-first into bytes and queues them in a FIFO.
// Optional macro LFSR_PACK_DROP_CNT_EN adds drop_cnt_o, a saturating count of dropped bytes.
module lfsr_byte_packer
  import lfsr_pack_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [SEED_W-1:0]         seed_i,
  input  logic [LEN_W-1:0]          byte_len_i,
  output logic                      lfsr_load_o,
  output logic [SEED_W-1:0]         lfsr_seed_o,
  input  logic                      lfsr_q_i,
  lfsr_byte_packer_if.master        dout_if,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      seed_err_o,
`ifdef LFSR_PACK_DROP_CNT_EN
  output logic [BYTE_W-1:0]         drop_cnt_o,
`endif
  output logic                      overflow_o
);

  state_e                 state_q;
  logic [SEED_W-1:0]      lfsr_seed_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       byte_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BYTE_W-2:0]      shift_q;
  logic                   lfsr_load_q;
  logic                   done_q;
  logic                   seed_err_q;
  logic                   overflow_q;
`ifdef LFSR_PACK_DROP_CNT_EN
  logic [BYTE_W-1:0]      drop_cnt_q;
`endif

  logic byte_done;
  logic last_byte;
  logic fifo_accept;
  logic fifo_empty;
  logic byte_drop;

  assign byte_done = (state_q == RUN) && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
  assign last_byte = ((byte_cnt_q + LEN_W'(1)) == len_q);
  assign byte_drop = byte_done && !fifo_accept;

  lfsr_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (byte_done),
    .data_i   (pack_bit(shift_q, lfsr_q_i)),
    .pop_i    (dout_if.ready),
    .data_o   (dout_if.data),
    .accept_o (fifo_accept),
    .empty_o  (fifo_empty)
  );

  assign dout_if.valid = !fifo_empty;
  assign lfsr_load_o   = lfsr_load_q;
  assign lfsr_seed_o   = lfsr_seed_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign seed_err_o    = seed_err_q;
  assign overflow_o    = overflow_q;
`ifdef LFSR_PACK_DROP_CNT_EN
  assign drop_cnt_o    = drop_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_seed_q <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      lfsr_load_q <= 1'b0;
      done_q      <= 1'b0;
      seed_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef LFSR_PACK_DROP_CNT_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;

      // A dropped byte still counts toward the requested length.
      if (byte_drop) begin
        overflow_q <= 1'b1;
`ifdef LFSR_PACK_DROP_CNT_EN
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + BYTE_W'(1);
        end
`endif
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (seed_i == '0) begin
              seed_err_q <= 1'b1;
            end else if (byte_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= LOAD;
              lfsr_load_q <= 1'b1;
              lfsr_seed_q <= seed_i;
              len_q       <= byte_len_i;
              byte_cnt_q  <= '0;
              bit_cnt_q   <= '0;
              overflow_q  <= 1'b0;
`ifdef LFSR_PACK_DROP_CNT_EN
              drop_cnt_q  <= '0;
`endif
            end
          end
        end

        LOAD: begin
          state_q     <= RUN;
          lfsr_load_q <= 1'b0;
        end

        RUN: begin
          shift_q   <= {shift_q[BYTE_W-3:0], lfsr_q_i};
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          if (byte_done) begin
            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            if (last_byte) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          lfsr_load_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_byte_packer.sv
// Self-checking bench: packer plus real 4-bit LFSR, table-driven runs and hand-written corner sequences.
module tb_lfsr_byte_packer;

  typedef struct {
    logic [3:0]  seed;
    logic [15:0] len;
    logic [7:0]  first;
    int          exp_bytes;
    int          exp_done;
    int          exp_err;
    int          exp_load;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  seed;
  logic [15:0] byte_len;
  logic        lfsr_load;
  logic [3:0]  lfsr_seed;
  logic        lfsr_q;
  logic        busy;
  logic        done;
  logic        seed_err;
  logic        overflow;
`ifdef LFSR_PACK_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q [$];
  int n_done = 0;
  int n_err  = 0;
  int n_load = 0;

  vec_t vecs [9];

  always #5 clk = ~clk;

  lfsr_byte_packer_if bus ();

  lfsr_byte_packer #(
    .FIFO_DEPTH (16),
    .LEN_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .seed_i      (seed),
    .byte_len_i  (byte_len),
    .lfsr_load_o (lfsr_load),
    .lfsr_seed_o (lfsr_seed),
    .lfsr_q_i    (lfsr_q),
    .dout_if     (bus.master),
    .busy_o      (busy),
    .done_o      (done),
    .seed_err_o  (seed_err),
`ifdef LFSR_PACK_DROP_CNT_EN
    .drop_cnt_o  (drop_cnt),
`endif
    .overflow_o  (overflow)
  );

  lfsr4 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load),
    .seed_i (lfsr_seed),
    .q_o    (lfsr_q)
  );

  // Observe handshakes and pulses half a cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid && bus.ready) rx_q.push_back(bus.data);
      if (done)      n_done <= n_done + 1;
      if (seed_err)  n_err  <= n_err + 1;
      if (lfsr_load) n_load <= n_load + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Byte k of the stream for a seed: bit recurrence a[n] = a[n-4] ^ a[n-3], stream starts at a[4].
  function automatic logic [7:0] model_byte(input logic [3:0] s, input int k);
    logic a [0:299];
    logic [7:0] b;
    a[0] = s[3]; a[1] = s[2]; a[2] = s[1]; a[3] = s[0];
    for (int n = 4; n < 12 + 8 * k; n++) a[n] = a[n-4] ^ a[n-3];
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], a[4 + 8 * k + i]};
    return b;
  endfunction

  task automatic pulse_start(input logic [3:0] s, input logic [15:0] len);
    @(posedge clk); #1;
    seed = s; byte_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for the LOAD cycle; returns with the bench at that cycle's falling edge.
  task automatic wait_load(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (lfsr_load) seen = 1'b1;
    end
  endtask

  initial begin
    int base, n, errs;
    bit seen;

    vecs[0] = '{4'h1, 16'd1,  8'h35, 1,  1, 0, 1};
    vecs[1] = '{4'h8, 16'd1,  8'h9A, 1,  1, 0, 1};
    vecs[2] = '{4'hF, 16'd1,  8'h13, 1,  1, 0, 1};
    vecs[3] = '{4'h2, 16'd3,  8'h6B, 3,  1, 0, 1};
    vecs[4] = '{4'h1, 16'd15, 8'h35, 15, 1, 0, 1};
    vecs[5] = '{4'h1, 16'd16, 8'h35, 16, 1, 0, 1};
    vecs[6] = '{4'h0, 16'd5,  8'h00, 0,  0, 1, 0};
    vecs[7] = '{4'h3, 16'd0,  8'h00, 0,  1, 0, 0};
    vecs[8] = '{4'h0, 16'd0,  8'h00, 0,  0, 1, 0};

    rst = 1'b1; start = 1'b0; seed = '0; byte_len = '0; bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_valid",     32'(bus.valid), 32'd0);
    check("reset_done",      32'(done),      32'd0);
    check("reset_seed_err",  32'(seed_err),  32'd0);
    check("reset_overflow",  32'(overflow),  32'd0);
    check("reset_lfsr_load", 32'(lfsr_load), 32'd0);
    check("reset_lfsr_seed", 32'(lfsr_seed), 32'd0);
`ifdef LFSR_PACK_DROP_CNT_EN
    check("reset_drop_cnt",  32'(drop_cnt),  32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven runs with the consumer always ready.
    bus.ready = 1'b1;
    for (int v = 0; v < 9; v++) begin
      int d0, e0, l0;
      base = rx_q.size(); d0 = n_done; e0 = n_err; l0 = n_load;
      pulse_start(vecs[v].seed, vecs[v].len);
      @(negedge clk);
      check($sformatf("v%0d_busy_after_start", v), 32'(busy), 32'(vecs[v].exp_load));
      repeat (8 * int'(vecs[v].len) + 20) @(negedge clk);
      check($sformatf("v%0d_bytes", v), 32'(rx_q.size() - base), 32'(vecs[v].exp_bytes));
      check($sformatf("v%0d_done",  v), 32'(n_done - d0), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err",   v), 32'(n_err - e0),  32'(vecs[v].exp_err));
      check($sformatf("v%0d_load",  v), 32'(n_load - l0), 32'(vecs[v].exp_load));
      check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_overflow", v), 32'(overflow), 32'd0);
      if (vecs[v].exp_bytes > 0 && rx_q.size() > base) begin
        check($sformatf("v%0d_first", v), 32'(rx_q[base]), 32'(vecs[v].first));
        errs = 0;
        for (int k = 0; k < vecs[v].exp_bytes && base + k < rx_q.size(); k++)
          if (rx_q[base + k] !== model_byte(vecs[v].seed, k)) errs++;
        check($sformatf("v%0d_stream_mismatches", v), 32'(errs), 32'd0);
      end
    end
    check("len16_wraps_to_first", 32'(rx_q[rx_q.size() - 1]), 32'h35);

    // Consumer stalled: 16 bytes held, 4 dropped, then drained in order.
    bus.ready = 1'b0;
    pulse_start(4'h1, 16'd20);
    repeat (200) @(negedge clk);
    check("stall_overflow", 32'(overflow),  32'd1);
    check("stall_busy",     32'(busy),      32'd0);
    check("stall_valid",    32'(bus.valid), 32'd1);
`ifdef LFSR_PACK_DROP_CNT_EN
    check("stall_drop_cnt", 32'(drop_cnt),  32'd4);
`endif
    base = rx_q.size();
    @(posedge clk); #1 bus.ready = 1'b1;
    repeat (30) @(negedge clk);
    check("drain_count", 32'(rx_q.size() - base), 32'd16);
    errs = 0;
    for (int k = 0; k < 16 && base + k < rx_q.size(); k++)
      if (rx_q[base + k] !== model_byte(4'h1, k)) errs++;
    check("drain_order_mismatches", 32'(errs), 32'd0);
    check("drain_valid_end", 32'(bus.valid), 32'd0);
    check("drain_overflow_sticky", 32'(overflow), 32'd1);

    // Reset five cycles into RUN, then a clean restart.
    pulse_start(4'h1, 16'd4);
    wait_load(seen);
    check("rst_run_load_seen", 32'(seen), 32'd1);
    check("start_clears_overflow", 32'(overflow), 32'd0);
`ifdef LFSR_PACK_DROP_CNT_EN
    check("start_clears_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_valid", 32'(bus.valid), 32'd0);
    check("rst_mid_load",  32'(lfsr_load), 32'd0);
    base = rx_q.size();
    pulse_start(4'h1, 16'd1);
    wait_load(seen);
    check("restart_load_seen", 32'(seen), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (bus.valid) break;
    end
    check("first_byte_latency", 32'(n), 32'd9);
    check("restart_dout", 32'(bus.data), 32'h35);
    repeat (5) @(negedge clk);
    check("restart_bytes", 32'(rx_q.size() - base), 32'd1);

    // Full FIFO with a pop exactly on the completion cycle of byte 17; START while busy ignored.
    begin
      int d0, l0;
      bus.ready = 1'b0;
      base = rx_q.size(); d0 = n_done; l0 = n_load;
      pulse_start(4'h1, 16'd17);
      wait_load(seen);
      check("full_pop_load_seen", 32'(seen), 32'd1);
      repeat (20) @(posedge clk);
      #1 seed = 4'h8; byte_len = 16'd1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (115) @(posedge clk);
      #1 bus.ready = 1'b1;
      @(posedge clk); #1 bus.ready = 1'b0;
      repeat (20) @(negedge clk);
      check("full_pop_overflow", 32'(overflow), 32'd0);
      check("full_pop_done",     32'(n_done - d0), 32'd1);
      check("busy_start_ignored_load", 32'(n_load - l0), 32'd1);
      @(posedge clk); #1 bus.ready = 1'b1;
      repeat (30) @(negedge clk);
      check("full_pop_total_bytes", 32'(rx_q.size() - base), 32'd17);
      errs = 0;
      for (int k = 0; k < 17 && base + k < rx_q.size(); k++)
        if (rx_q[base + k] !== model_byte(4'h1, k)) errs++;
      check("full_pop_order_mismatches", 32'(errs), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
